// File: rtl/mem_bus_arbiter.sv
// Two-requester memory bus arbiter: instruction fetch (read-only) and
// load/store share one memory controller port, with round-robin on ties.
// One transaction is in flight at a time; reads return after RD_LAT cycles.
// RD_LAT must be in the range 1..4.
module mem_bus_arbiter #(
  parameter int unsigned ADDR_W = 10,
  parameter int unsigned DATA_W = 32,
  parameter int unsigned RD_LAT = 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              if_req,
  input  logic [ADDR_W-1:0] if_addr,
  output logic              if_gnt,
  output logic              if_rvalid,
  output logic [DATA_W-1:0] if_rdata,
  input  logic              ls_req,
  input  logic              ls_we,
  input  logic [ADDR_W-1:0] ls_addr,
  input  logic [DATA_W-1:0] ls_wdata,
  output logic              ls_gnt,
  output logic              ls_rvalid,
  output logic [DATA_W-1:0] ls_rdata,
  output logic [ADDR_W-1:0] mem_addr,
  output logic              mem_wr_en,
  output logic              mem_rd_en,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata
);

  localparam int unsigned CNT_W = 2;

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_ISSUE = 2'd1;
  localparam logic [1:0] S_WAIT  = 2'd2;
  localparam logic [1:0] S_RESP  = 2'd3;

  logic [1:0]       state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             armed_q, armed_d;     // blocks sampling on the first edge after reset
  logic             last_ls_q, last_ls_d; // 1 = load/store won the previous grant
  logic             sel_ls_q, sel_ls_d;   // owner of the transaction in flight
  logic             is_wr_q, is_wr_d;

  logic              if_gnt_d, if_rvalid_d, ls_gnt_d, ls_rvalid_d;
  logic              mem_wr_en_d, mem_rd_en_d;
  logic [DATA_W-1:0] if_rdata_d, ls_rdata_d, mem_wdata_d;
  logic [ADDR_W-1:0] mem_addr_d;
  logic              pick_ls;

  // Next-state and next-output logic; outputs are registered below.
  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    armed_d     = 1'b1;
    last_ls_d   = last_ls_q;
    sel_ls_d    = sel_ls_q;
    is_wr_d     = is_wr_q;
    if_gnt_d    = 1'b0;
    ls_gnt_d    = 1'b0;
    if_rvalid_d = 1'b0;
    ls_rvalid_d = 1'b0;
    mem_wr_en_d = 1'b0;
    mem_rd_en_d = 1'b0;
    mem_addr_d  = mem_addr;
    mem_wdata_d = mem_wdata;
    if_rdata_d  = if_rdata;
    ls_rdata_d  = ls_rdata;
    pick_ls     = ls_req && (!if_req || !last_ls_q);

    case (state_q)
      S_IDLE: begin
        if (armed_q && (if_req || ls_req)) begin
          state_d   = S_ISSUE;
          sel_ls_d  = pick_ls;
          last_ls_d = pick_ls;
          is_wr_d   = pick_ls && ls_we;
          if (pick_ls) begin
            ls_gnt_d    = 1'b1;
            mem_addr_d  = ls_addr;
            mem_wdata_d = ls_wdata;
            mem_wr_en_d = ls_we;
            mem_rd_en_d = !ls_we;
          end else begin
            if_gnt_d    = 1'b1;
            mem_addr_d  = if_addr;
            mem_wdata_d = '0;
            mem_rd_en_d = 1'b1;
          end
        end
      end
      S_ISSUE: begin
        if (is_wr_q) begin
          state_d = S_IDLE;
        end else begin
          state_d = S_WAIT;
          cnt_d   = CNT_W'(RD_LAT - 1);
        end
      end
      S_WAIT: begin
        if (cnt_q == '0) begin
          state_d = S_RESP;
          if (sel_ls_q) begin
            ls_rvalid_d = 1'b1;
            ls_rdata_d  = mem_rdata;
          end else begin
            if_rvalid_d = 1'b1;
            if_rdata_d  = mem_rdata;
          end
        end else begin
          cnt_d = cnt_q - CNT_W'(1);
        end
      end
      S_RESP: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // State and output registers; reset aborts any transaction in flight.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q   <= S_IDLE;
      cnt_q     <= '0;
      armed_q   <= 1'b0;
      last_ls_q <= 1'b1;
      sel_ls_q  <= 1'b0;
      is_wr_q   <= 1'b0;
      if_gnt    <= 1'b0;
      if_rvalid <= 1'b0;
      if_rdata  <= '0;
      ls_gnt    <= 1'b0;
      ls_rvalid <= 1'b0;
      ls_rdata  <= '0;
      mem_addr  <= '0;
      mem_wr_en <= 1'b0;
      mem_rd_en <= 1'b0;
      mem_wdata <= '0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      armed_q   <= armed_d;
      last_ls_q <= last_ls_d;
      sel_ls_q  <= sel_ls_d;
      is_wr_q   <= is_wr_d;
      if_gnt    <= if_gnt_d;
      if_rvalid <= if_rvalid_d;
      if_rdata  <= if_rdata_d;
      ls_gnt    <= ls_gnt_d;
      ls_rvalid <= ls_rvalid_d;
      ls_rdata  <= ls_rdata_d;
      mem_addr  <= mem_addr_d;
      mem_wr_en <= mem_wr_en_d;
      mem_rd_en <= mem_rd_en_d;
      mem_wdata <= mem_wdata_d;
    end
  end

endmodule

// File: tb/tb_mem_bus_arbiter.sv
// Bench for mem_bus_arbiter: a RD_LAT=3 instance checked every cycle against
// a transaction-scheduling model, plus a RD_LAT=1 instance for a single fetch.
module tb_mem_bus_arbiter;

  localparam int unsigned ADDR_W = 10;
  localparam int unsigned DATA_W = 32;
  localparam int LAT = 3;

  logic clk = 1'b0;
  logic rst;

  logic              if_req, ls_req, ls_we;
  logic [ADDR_W-1:0] if_addr, ls_addr, mem_addr;
  logic [DATA_W-1:0] ls_wdata, if_rdata, ls_rdata, mem_wdata, mem_rdata;
  logic              if_gnt, if_rvalid, ls_gnt, ls_rvalid, mem_wr_en, mem_rd_en;

  logic              if_req_1, ls_req_1, ls_we_1;
  logic [ADDR_W-1:0] if_addr_1, ls_addr_1, mem_addr_1;
  logic [DATA_W-1:0] ls_wdata_1, if_rdata_1, ls_rdata_1, mem_wdata_1, mem_rdata_1;
  logic              if_gnt_1, if_rvalid_1, ls_gnt_1, ls_rvalid_1, mem_wr_en_1, mem_rd_en_1;

  int checks = 0;
  int errors = 0;

  // model state: edge index, arming edge, transaction in flight
  int  k = 0, next_s = 0, t_e = 0;
  bit  busy = 0, t_ls = 0, t_wr = 0, last_ls = 1, wd_valid = 0, agent_on = 0;
  logic e_if_gnt, e_ls_gnt, e_rd, e_wr, e_if_rv, e_ls_rv;
  logic [ADDR_W-1:0] e_addr;
  logic [DATA_W-1:0] e_wdata, e_if_rdata, e_ls_rdata;

  bit       rec_order = 0;
  logic [3:0] ord = '0;
  int       n_ord = 0;

  mem_bus_arbiter #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .RD_LAT(LAT)) u_dut (
    .clk(clk), .rst(rst),
    .if_req(if_req), .if_addr(if_addr), .if_gnt(if_gnt), .if_rvalid(if_rvalid), .if_rdata(if_rdata),
    .ls_req(ls_req), .ls_we(ls_we), .ls_addr(ls_addr), .ls_wdata(ls_wdata),
    .ls_gnt(ls_gnt), .ls_rvalid(ls_rvalid), .ls_rdata(ls_rdata),
    .mem_addr(mem_addr), .mem_wr_en(mem_wr_en), .mem_rd_en(mem_rd_en),
    .mem_wdata(mem_wdata), .mem_rdata(mem_rdata)
  );

  mem_bus_arbiter #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .RD_LAT(1)) u_dut1 (
    .clk(clk), .rst(rst),
    .if_req(if_req_1), .if_addr(if_addr_1), .if_gnt(if_gnt_1), .if_rvalid(if_rvalid_1), .if_rdata(if_rdata_1),
    .ls_req(ls_req_1), .ls_we(ls_we_1), .ls_addr(ls_addr_1), .ls_wdata(ls_wdata_1),
    .ls_gnt(ls_gnt_1), .ls_rvalid(ls_rvalid_1), .ls_rdata(ls_rdata_1),
    .mem_addr(mem_addr_1), .mem_wr_en(mem_wr_en_1), .mem_rd_en(mem_rd_en_1),
    .mem_wdata(mem_wdata_1), .mem_rdata(mem_rdata_1)
  );

  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    busy = 0; last_ls = 1; wd_valid = 0;
    e_if_gnt = 0; e_ls_gnt = 0; e_rd = 0; e_wr = 0; e_if_rv = 0; e_ls_rv = 0;
    e_addr = '0; e_wdata = '0; e_if_rdata = '0; e_ls_rdata = '0;
  endtask

  // Predict what the arbiter shows after the coming clock edge.
  task automatic model_edge();
    k++;
    e_if_gnt = 0; e_ls_gnt = 0; e_rd = 0; e_wr = 0; e_if_rv = 0; e_ls_rv = 0;
    if (busy && !t_wr && k == t_e + LAT + 1) begin
      if (t_ls) begin e_ls_rv = 1; e_ls_rdata = mem_rdata; end
      else      begin e_if_rv = 1; e_if_rdata = mem_rdata; end
    end
    if (busy && k >= t_e + (t_wr ? 2 : LAT + 3)) busy = 0;
    if (!busy && k >= next_s && (if_req || ls_req)) begin
      if (if_req && ls_req) t_ls = !last_ls;
      else                  t_ls = ls_req;
      t_wr = t_ls && ls_we;
      last_ls = t_ls; busy = 1; t_e = k;
      e_if_gnt = !t_ls; e_ls_gnt = t_ls; e_wr = t_wr; e_rd = !t_wr;
      e_addr = t_ls ? ls_addr : if_addr;
      wd_valid = t_wr;
      if (t_wr) e_wdata = ls_wdata;
    end
  endtask

  task automatic agent();
    if (e_if_gnt) begin
      if_req = 1'($urandom_range(0, 1)); if_addr = ADDR_W'($urandom);
    end else if (!if_req) begin
      if ($urandom_range(0, 2) == 0) begin if_req = 1; if_addr = ADDR_W'($urandom); end
    end else if ($urandom_range(0, 19) == 0) if_req = 0;
    if (e_ls_gnt || (!ls_req && $urandom_range(0, 2) == 0)) begin
      ls_req = e_ls_gnt ? 1'($urandom_range(0, 1)) : 1'b1;
      ls_we  = 1'($urandom_range(0, 1));
      case ($urandom_range(0, 3))
        0: ls_addr = 10'h3FF;
        1: ls_addr = 10'h3FE;
        2: ls_addr = 10'h3EF;
        default: ls_addr = ADDR_W'($urandom);
      endcase
      ls_wdata = $urandom;
    end else if (ls_req && $urandom_range(0, 19) == 0) ls_req = 0;
  endtask

  task automatic check_all_zero(input string tag);
    chk({tag, "_if_gnt"}, 32'(if_gnt), 0);
    chk({tag, "_ls_gnt"}, 32'(ls_gnt), 0);
    chk({tag, "_if_rvalid"}, 32'(if_rvalid), 0);
    chk({tag, "_ls_rvalid"}, 32'(ls_rvalid), 0);
    chk({tag, "_if_rdata"}, if_rdata, 0);
    chk({tag, "_ls_rdata"}, ls_rdata, 0);
    chk({tag, "_mem_addr"}, 32'(mem_addr), 0);
    chk({tag, "_mem_wr_en"}, 32'(mem_wr_en), 0);
    chk({tag, "_mem_rd_en"}, 32'(mem_rd_en), 0);
    chk({tag, "_mem_wdata"}, mem_wdata, 0);
  endtask

  // One clock cycle: drive in the low phase, predict, check after the edge.
  task automatic cycle();
    mem_rdata = $urandom;
    if (agent_on) agent();
    model_edge();
    @(posedge clk);
    #1;
    chk("if_gnt", 32'(if_gnt), 32'(e_if_gnt));
    chk("ls_gnt", 32'(ls_gnt), 32'(e_ls_gnt));
    chk("mem_rd_en", 32'(mem_rd_en), 32'(e_rd));
    chk("mem_wr_en", 32'(mem_wr_en), 32'(e_wr));
    chk("if_rvalid", 32'(if_rvalid), 32'(e_if_rv));
    chk("ls_rvalid", 32'(ls_rvalid), 32'(e_ls_rv));
    chk("mem_addr", 32'(mem_addr), 32'(e_addr));
    chk("if_rdata", if_rdata, e_if_rdata);
    chk("ls_rdata", ls_rdata, e_ls_rdata);
    if (wd_valid) chk("mem_wdata", mem_wdata, e_wdata);
    chk("gnt_exclusive", 32'(if_gnt & ls_gnt), 0);
    chk("strobe_exclusive", 32'(mem_rd_en & mem_wr_en), 0);
    if (rec_order && (if_gnt || ls_gnt) && n_ord < 4) begin
      ord[n_ord] = ls_gnt;
      n_ord++;
    end
    @(negedge clk);
  endtask

  task automatic wait_gnt(input bit want_ls, output int edge_at);
    bit found = 0;
    edge_at = -1;
    for (int i = 0; i < 12 && !found; i++) begin
      cycle();
      if (want_ls ? e_ls_gnt : e_if_gnt) begin found = 1; edge_at = k; end
    end
    chk(want_ls ? "ls_gnt_timeout" : "if_gnt_timeout", 32'(found), 1);
  endtask

  initial begin
    int c0, c1, rv_edge, g_edge;
    logic [31:0] exp1;

    rst = 1;
    if_req = 0; if_addr = '0; ls_req = 0; ls_we = 0; ls_addr = '0; ls_wdata = '0; mem_rdata = '0;
    if_req_1 = 0; if_addr_1 = '0; ls_req_1 = 0; ls_we_1 = 0; ls_addr_1 = '0; ls_wdata_1 = '0;
    mem_rdata_1 = 32'hDEADBEEF;
    model_reset();
    #2 rst = 0;
    #1 check_all_zero("reset");
    @(negedge clk);
    @(negedge clk);

    // both requesters held high from release; fetch-only on the RD_LAT=1 copy
    rst = 1; next_s = k + 2;
    if_req = 1; if_addr = 10'h100;
    ls_req = 1; ls_we = 0; ls_addr = 10'h0AA;
    if_req_1 = 1; if_addr_1 = 10'h010;
    rec_order = 1;
    for (int i = 1; i <= 26; i++) begin
      cycle();
      if (i <= 6) begin
        chk("f1_if_gnt", 32'(if_gnt_1), 32'(i == 2));
        chk("f1_rd_en", 32'(mem_rd_en_1), 32'(i == 2));
        chk("f1_wr_en", 32'(mem_wr_en_1), 0);
        chk("f1_addr", 32'(mem_addr_1), (i >= 2) ? 32'h010 : 32'h0);
        chk("f1_if_rvalid", 32'(if_rvalid_1), 32'(i == 4));
        exp1 = (i >= 4) ? 32'hDEADBEEF : 32'h0;
        chk("f1_if_rdata", if_rdata_1, exp1);
        chk("f1_ls_quiet", 32'(ls_gnt_1 | ls_rvalid_1) | ls_rdata_1, 0);
      end
      if (i == 2) if_req_1 = 0;
    end
    rec_order = 0;
    chk("grant_count", 32'(n_ord), 4);
    chk("grant_order", 32'(ord), 32'b1010);
    if_req = 0; ls_req = 0;
    repeat (8) cycle();

    // load from 0x3EF, with a fetch queued right behind it
    ls_req = 1; ls_we = 0; ls_addr = 10'h3EF;
    wait_gnt(1, c0);
    ls_req = 0; if_req = 1; if_addr = 10'h3FE;
    rv_edge = -1; g_edge = -1;
    for (int i = 0; i < 10; i++) begin
      cycle();
      if (ls_rvalid && rv_edge < 0) rv_edge = k;
      if (if_gnt && g_edge < 0) begin g_edge = k; if_req = 0; end
    end
    chk("load_rvalid_edge", 32'(rv_edge - c0), 4);
    chk("next_gnt_not_early", 32'(g_edge - c0 >= 5), 1);
    repeat (6) cycle();

    // back-to-back stores to the top of the MMIO range
    ls_req = 1; ls_we = 1; ls_addr = 10'h3FF; ls_wdata = 32'h25;
    wait_gnt(1, c0);
    ls_addr = 10'h3FE; ls_wdata = 32'hA5;
    wait_gnt(1, c1);
    chk("store_gap", 32'(c1 - c0), 2);
    ls_req = 0; ls_we = 0;
    repeat (4) cycle();

    // randomized traffic
    agent_on = 1;
    repeat (400) cycle();
    agent_on = 0;
    if_req = 0; ls_req = 0;
    repeat (10) cycle();

    // reset while a fetch waits for data, then a clean fetch
    if_req = 1; if_addr = 10'h155;
    wait_gnt(0, c0);
    if_req = 0;
    cycle();
    rst = 0;
    #1 check_all_zero("midwait");
    model_reset();
    @(negedge clk);
    @(negedge clk);
    rst = 1; next_s = k + 2;
    if_req = 1; if_addr = 10'h2AA;
    wait_gnt(0, c0);
    chk("post_reset_gnt_edge", 32'(c0 >= next_s), 1);
    if_req = 0;
    repeat (10) cycle();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/mem_bus_arbiter.md
MEM_BUS_ARBITER -- requirements
Module: mem_bus_arbiter

Interface
REQ-001 Parameter ADDR_W, default 10, address width of all address ports.
REQ-002 Parameter DATA_W, default 32, data width of all data ports.
REQ-003 Parameter RD_LAT, default 1, legal 1-4, cycles from mem_rd_en high to mem_rdata valid.
REQ-004 clk  in  1  single clock, all state on rising edge.
REQ-005 rst  in  1  reset, asynchronous, active-low.
REQ-006 if_req  in  1  instruction-fetch read request.
REQ-007 if_addr  in  ADDR_W  fetch address.
REQ-008 if_gnt  out  1  one-cycle grant pulse to fetch.
REQ-009 if_rvalid  out  1  one-cycle fetch read-data valid.
REQ-010 if_rdata  out  DATA_W  fetch read data.
REQ-011 ls_req  in  1  load/store request.
REQ-012 ls_we  in  1  1 = store, 0 = load.
REQ-013 ls_addr  in  ADDR_W  load/store address.
REQ-014 ls_wdata  in  DATA_W  store data.
REQ-015 ls_gnt  out  1  one-cycle grant pulse to load/store.
REQ-016 ls_rvalid  out  1  one-cycle load-data valid.
REQ-017 ls_rdata  out  DATA_W  load data.
REQ-018 mem_addr  out  ADDR_W  address to memory controller.
REQ-019 mem_wr_en  out  1  write strobe to memory controller.
REQ-020 mem_rd_en  out  1  read strobe to memory controller.
REQ-021 mem_wdata  out  DATA_W  write data to memory controller.
REQ-022 mem_rdata  in  DATA_W  read data from memory controller.

Function
REQ-023 All outputs SHALL be registered.
REQ-024 FSM states SHALL be IDLE, ISSUE, WAIT, RESP.
REQ-025 IDLE: any req high at clock edge -> ISSUE; none -> stay IDLE; requests SHALL be sampled only in IDLE.
REQ-026 Arbitration: single requester wins; both requesting -> requester not granted last wins (round-robin); pointer updates at each grant.
REQ-027 ISSUE (cycle C0): winner gnt=1, mem_addr/mem_wdata = winner's captured values, exactly one of mem_rd_en/mem_wr_en =1 (fetch always read).
REQ-028 ISSUE store -> IDLE at C0+1; no rvalid for stores; next grant earliest C0+2.
REQ-029 ISSUE read -> WAIT; WAIT counts RD_LAT cycles; mem_rdata captured at end of cycle C0+RD_LAT.
REQ-030 RESP (cycle C0+RD_LAT+1): winner rvalid=1 one cycle, rdata = captured value; -> IDLE; next grant earliest C0+RD_LAT+2.
REQ-031 Strobes, gnt and rvalid SHALL be one-cycle pulses; mem_rd_en and mem_wr_en SHALL never be high together; at most one gnt and one rvalid high per cycle.
REQ-032 mem_addr/mem_wdata SHALL hold from ISSUE through RESP; if_rdata/ls_rdata SHALL hold last value until next own response.
REQ-033 Requester SHALL hold req/addr/we/wdata stable until gnt; req may drop cycle after gnt; req dropped before grant is ignored without side effect.
REQ-034 No address filtering; all ADDR_W values (incl. 0x3FF, 0x3FE, 0x3EF MMIO) SHALL pass through unchanged.

Reset
REQ-035 rst low SHALL immediately force state IDLE, all outputs 0, round-robin pointer so fetch wins first tie.
REQ-036 rst low in ISSUE/WAIT/RESP SHALL abort the transaction; no rvalid for it after release.
REQ-037 First grant after rst high SHALL occur no earlier than the second rising edge after release.

Verification
REQ-038 rst low mid-WAIT -> all outputs 0 without clock edge; after release no stale rvalid; new fetch completes normally.
REQ-039 RD_LAT=1, fetch only, if_addr=0x010, mem_rdata=0xDEADBEEF -> C0: if_gnt=1, mem_rd_en=1, mem_addr=0x010; C0+2: if_rvalid=1, if_rdata=0xDEADBEEF; ls_* stay 0.
REQ-040 Store ls_addr=0x3FF, ls_wdata=0x25 -> C0: ls_gnt=1, mem_wr_en=1, mem_rd_en=0, mem_wdata=0x25; no ls_rvalid; IDLE at C0+1.
REQ-041 Both requesting continuously after reset -> grant order IF, LS, IF, LS; never two gnts same cycle.
REQ-042 RD_LAT=3, load ls_addr=0x3EF -> ls_rvalid exactly at C0+4 with mem_rdata of C0+3; next grant at C0+5 earliest.
REQ-043 Back-to-back stores 0x3FF then 0x3FE -> ls_gnt at C0 and C0+2, mem_wr_en pulses match, mem_addr follows.
